niveles_necesidades: RTL and testbench
======================================

Name: niveles_necesidades

Overview:
Upstream stage of the tamagotchi state machine; generates its `hambre` and `diversion` level inputs (range 1..5).
- Hunger rises and fun decays on timed periods derived from a 1-second prescaler.
- Debounced active-low "feed" and "play" buttons push the levels back toward healthy values.
- Consumes the FSM's `estado` as feedback so all levels freeze once the pet is MUERTO.

Parameters:
- TICK_CYCLES, 50000000, clk cycles per 1-second tick (minimum 2).
- HAMBRE_PERIOD, 10, ticks between automatic hambre increments (minimum 1).
- DIVERSION_PERIOD, 8, ticks between automatic diversion decrements (minimum 1).
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a button level change (minimum 1).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- boton_comer_n  input  1  feed button, active-low, asynchronous to clk.
- boton_jugar_n  input  1  play button, active-low, asynchronous to clk.
- estado  input  3  current FSM state; 3'b101 = MUERTO.
- hambre  output  3  hunger level, 1 (satiated) .. 5 (starving).
- diversion  output  3  fun level, 1 (bored) .. 5 (max).
- evento_comer  output  1  one-cycle pulse when a feed press is applied.
- evento_jugar  output  1  one-cycle pulse when a play press is applied.

Behaviour:
- One clock. Reset is synchronous, active-low: sampled only on posedge clk while reset_n=0; reset_n asserted mid-operation takes effect on the next edge.
- Reset values:
  - hambre=1, diversion=5, evento_comer=0, evento_jugar=0.
  - Prescaler, both period timers and debounce counters = 0.
  - Synchronizer flops and debounced button states = 1 (released).
- Prescaler:
  - Counts 0..TICK_CYCLES-1.
  - `tick` is high for one cycle on the cycle the count equals TICK_CYCLES-1, then the count wraps to 0.
  - The prescaler free-runs, including while MUERTO.
- Button path (each button independent):
  - 2-flop synchronizer, then debouncer.
  - Debounce counter increments while the synchronized sample differs from the debounced state; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears.
  - A press is the debounced 1->0 transition; exactly one press per physical press.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press latency: the level change and its evento pulse are registered on the clock edge after the debounced state falls (registered output). Total latency from pin low is 2 + DEBOUNCE_CYCLES + 1 edges.
- Hunger timer:
  - Counts ticks 0..HAMBRE_PERIOD-1.
  - On the tick where the count equals HAMBRE_PERIOD-1: hambre = min(hambre+1, 5) and the count wraps to 0.
- Fun timer:
  - Counts ticks 0..DIVERSION_PERIOD-1.
  - On its terminal tick: diversion = max(diversion-1, 1) and the count wraps to 0.
- Feed press:
  - hambre = max(hambre-1, 1) and the hunger timer clears to 0.
  - evento_comer pulses even when hambre is already 1 (saturated).
- Play press:
  - diversion = min(diversion+1, 5) and the fun timer clears to 0.
  - Same pulse-on-saturation rule applies (evento_jugar pulses even when diversion is already 5).
- Simultaneous events:
  - Press and terminal tick in the same cycle: the press wins. The timer-driven step is suppressed and the timer clears, giving a net change of one step toward healthy.
  - Feed and play in the same cycle: both are applied independently.
- Arithmetic: levels are 3-bit unsigned and never leave 1..5. Saturation is checked before update, with no wrap to 0 or 6.
- MUERTO (estado==3'b101):
  - hambre and diversion hold their values.
  - Both timers hold.
  - Presses are still debounced but discarded: no level change and no evento pulse.
  - When estado leaves 3'b101, timers resume from their held counts.
- estado values 3'b110/3'b111 are treated as not MUERTO.

Test Plan:
1. Reset then run, with TICK_CYCLES=4, HAMBRE_PERIOD=3, DIVERSION_PERIOD=2, DEBOUNCE_CYCLES=3 (also used by the scenarios below):
   - After reset: hambre=1, diversion=5.
   - After 12 ticks (48 cycles): hambre=5, diversion=1.
   - Both levels stay saturated at those values through 40 more ticks.
2. With hambre=4, hold boton_comer_n low for 20 cycles:
   - hambre=3 exactly 6 edges after the pin falls; evento_comer is high for that single cycle.
   - No second decrement while the button is held.
   - The next hambre increment comes 3 full ticks later.
3. Bounce: pulse boton_jugar_n low for 2 cycles, five times, separated by 2 high cycles -> diversion unchanged and evento_jugar never asserts.
4. Collision: time a feed press so its apply cycle coincides with the hunger terminal tick, with hambre=3 -> hambre=2 (not 3 or 4) and the timer restarts at 0.
5. Dead state: drive estado=3'b101 with hambre=5, diversion=1:
   - Over 50 ticks plus feed and play presses: levels stay at 5/1 and there are no evento pulses.
   - Set estado=3'b000: the next hambre step comes after the remaining held count.
6. Mid-run reset:
   - Assert reset_n=0 for exactly one edge with hambre=3, mid-debounce -> next cycle hambre=1, diversion=5, no evento pulse.
   - Asserting reset_n without a clock edge changes nothing.

Source files
------------

// File: rtl/niveles_necesidades.sv
// Hunger/fun level generator feeding the tamagotchi FSM: timed decay from a
// 1 s prescaler, debounced feed/play buttons, and a full freeze while MUERTO.
module niveles_necesidades #(
    parameter int unsigned TICK_CYCLES      = 50000000,
    parameter int unsigned HAMBRE_PERIOD    = 10,
    parameter int unsigned DIVERSION_PERIOD = 8,
    parameter int unsigned DEBOUNCE_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       boton_comer_n,
    input  logic       boton_jugar_n,
    input  logic [2:0] estado,
    output logic [2:0] hambre,
    output logic [2:0] diversion,
    output logic       evento_comer,
    output logic       evento_jugar
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam int unsigned HW = (HAMBRE_PERIOD > 1) ? $clog2(HAMBRE_PERIOD) : 1;
    localparam int unsigned VW = (DIVERSION_PERIOD > 1) ? $clog2(DIVERSION_PERIOD) : 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] HT_LAST    = HW'(HAMBRE_PERIOD - 1);
    localparam logic [VW-1:0] VT_LAST    = VW'(DIVERSION_PERIOD - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] MUERTO  = 3'b101;
    localparam logic [2:0] LVL_MIN = 3'd1;
    localparam logic [2:0] LVL_MAX = 3'd5;

    logic [PW-1:0]         presc_q, presc_d;
    logic [HW-1:0]         ht_q, ht_d;
    logic [VW-1:0]         vt_q, vt_d;
    logic [2:0]            hambre_q, hambre_d;
    logic [2:0]            diversion_q, diversion_d;
    logic                  ev_comer_q, ev_comer_d;
    logic                  ev_jugar_q, ev_jugar_d;

    // Button arrays: index 0 = comer, index 1 = jugar.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_dly_q, deb_dly_d;
    logic [1:0][DW-1:0]    cnt_q, cnt_d;

    logic                  tick;
    logic                  muerto;
    logic [1:0]            press;

    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        muerto  = (estado == MUERTO);
    end

    always_comb begin
        sync1_d   = {boton_jugar_n, boton_comer_n};
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        cnt_d     = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Press seen one cycle after the debounced fall, so the level update is registered.
        press = deb_dly_q & ~deb_q;
    end

    always_comb begin
        hambre_d    = hambre_q;
        diversion_d = diversion_q;
        ht_d        = ht_q;
        vt_d        = vt_q;
        ev_comer_d  = 1'b0;
        ev_jugar_d  = 1'b0;
        if (!muerto) begin
            // A press overrides a coincident terminal tick and restarts its timer.
            if (press[0]) begin
                ev_comer_d = 1'b1;
                ht_d       = '0;
                if (hambre_q > LVL_MIN) hambre_d = hambre_q - 3'd1;
            end else if (tick) begin
                if (ht_q == HT_LAST) begin
                    ht_d = '0;
                    if (hambre_q < LVL_MAX) hambre_d = hambre_q + 3'd1;
                end else begin
                    ht_d = ht_q + 1'b1;
                end
            end

            if (press[1]) begin
                ev_jugar_d = 1'b1;
                vt_d       = '0;
                if (diversion_q < LVL_MAX) diversion_d = diversion_q + 3'd1;
            end else if (tick) begin
                if (vt_q == VT_LAST) begin
                    vt_d = '0;
                    if (diversion_q > LVL_MIN) diversion_d = diversion_q - 3'd1;
                end else begin
                    vt_d = vt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q     <= '0;
            ht_q        <= '0;
            vt_q        <= '0;
            hambre_q    <= LVL_MIN;
            diversion_q <= LVL_MAX;
            ev_comer_q  <= 1'b0;
            ev_jugar_q  <= 1'b0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            deb_q       <= '1;
            deb_dly_q   <= '1;
            cnt_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            ht_q        <= ht_d;
            vt_q        <= vt_d;
            hambre_q    <= hambre_d;
            diversion_q <= diversion_d;
            ev_comer_q  <= ev_comer_d;
            ev_jugar_q  <= ev_jugar_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_dly_d;
            cnt_q       <= cnt_d;
        end
    end

    assign hambre       = hambre_q;
    assign diversion    = diversion_q;
    assign evento_comer = ev_comer_q;
    assign evento_jugar = ev_jugar_q;

endmodule

// File: tb/tb_niveles_necesidades.sv
// Directed bench for niveles_necesidades with small timing parameters
// (tick = 4 clk, hunger period 3 ticks, fun period 2 ticks, debounce 3).
module tb_niveles_necesidades;

    logic       clk;
    logic       reset_n;
    logic       boton_comer_n;
    logic       boton_jugar_n;
    logic [2:0] estado;
    logic [2:0] hambre;
    logic [2:0] diversion;
    logic       evento_comer;
    logic       evento_jugar;

    niveles_necesidades #(
        .TICK_CYCLES      (4),
        .HAMBRE_PERIOD    (3),
        .DIVERSION_PERIOD (2),
        .DEBOUNCE_CYCLES  (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .boton_comer_n (boton_comer_n),
        .boton_jugar_n (boton_jugar_n),
        .estado        (estado),
        .hambre        (hambre),
        .diversion     (diversion),
        .evento_comer  (evento_comer),
        .evento_jugar  (evento_jugar)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running pulse counts, sampled on the falling edge.
    int n_ec = 0;
    int n_ej = 0;
    always @(negedge clk) begin
        if (evento_comer === 1'b1) n_ec++;
        if (evento_jugar === 1'b1) n_ej++;
    end

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         adv;     // edges to advance after driving; 0 = short wait, no edge
        logic       rst_n;
        logic       comer_n;
        logic       jugar_n;
        logic [2:0] est;
        logic [2:0] h;
        logic [2:0] d;
        logic       ec;
        logic       ej;
    } vec_t;

    vec_t tbl[$];
    int   nxt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic add(input int adv, input logic r, input logic c, input logic j,
                       input logic [2:0] e, input logic [2:0] h, input logic [2:0] d,
                       input logic ec, input logic ej);
        vec_t v;
        v.adv = adv; v.rst_n = r; v.comer_n = c; v.jugar_n = j; v.est = e;
        v.h = h; v.d = d; v.ec = ec; v.ej = ej;
        tbl.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to(input int last);
        for (int i = nxt; i <= last; i++) begin
            reset_n       = tbl[i].rst_n;
            boton_comer_n = tbl[i].comer_n;
            boton_jugar_n = tbl[i].jugar_n;
            estado        = tbl[i].est;
            if (tbl[i].adv == 0) #2;
            else step(tbl[i].adv);
            chk($sformatf("row%0d hambre", i), 32'(hambre), 32'(tbl[i].h));
            chk($sformatf("row%0d diversion", i), 32'(diversion), 32'(tbl[i].d));
            chk($sformatf("row%0d evento_comer", i), 32'(evento_comer), 32'(tbl[i].ec));
            chk($sformatf("row%0d evento_jugar", i), 32'(evento_jugar), 32'(tbl[i].ej));
        end
        nxt = last + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec0, ej0;
        // Edge numbers Ek below count from the reset edge E0 of each segment.
        // A: reset, ramp to saturation, hold saturated (rows 0-4)
        add(2,   0, 1, 1, 3'b000, 1, 5, 0, 0);
        add(1,   1, 1, 1, 3'b000, 1, 5, 0, 0);  // E1
        add(46,  1, 1, 1, 3'b000, 4, 1, 0, 0);  // E47
        add(1,   1, 1, 1, 3'b000, 5, 1, 0, 0);  // E48: 12th tick
        add(160, 1, 1, 1, 3'b000, 5, 1, 0, 0);  // 40 more ticks
        // B: feed with hambre=4, held 20 cycles (rows 5-13)
        add(1,   0, 1, 1, 3'b000, 1, 5, 0, 0);
        add(36,  1, 1, 1, 3'b000, 4, 1, 0, 0);  // E36
        add(5,   1, 0, 1, 3'b000, 4, 1, 0, 0);  // E41
        add(1,   1, 0, 1, 3'b000, 3, 1, 1, 0);  // E42: 6 edges after pin fall
        add(1,   1, 0, 1, 3'b000, 3, 1, 0, 0);  // E43
        add(8,   1, 0, 1, 3'b000, 3, 1, 0, 0);  // E51
        add(1,   1, 0, 1, 3'b000, 4, 1, 0, 0);  // E52: 3 ticks after feed
        add(4,   1, 0, 1, 3'b000, 4, 1, 0, 0);  // E56
        add(9,   1, 1, 1, 3'b000, 5, 1, 0, 0);  // E65
        // C: setup for bounce, estado=111 is not MUERTO (rows 14-15)
        add(1,   0, 1, 1, 3'b111, 1, 5, 0, 0);
        add(8,   1, 1, 1, 3'b111, 1, 4, 0, 0);  // E8
        // D: feed apply collides with hunger terminal tick, estado=110 (rows 16-21)
        add(1,   0, 1, 1, 3'b110, 1, 5, 0, 0);
        add(30,  1, 1, 1, 3'b110, 3, 2, 0, 0);  // E30
        add(5,   1, 0, 1, 3'b110, 3, 1, 0, 0);  // E35
        add(1,   1, 0, 1, 3'b110, 2, 1, 1, 0);  // E36: press wins
        add(11,  1, 1, 1, 3'b110, 2, 1, 0, 0);  // E47
        add(1,   1, 1, 1, 3'b110, 3, 1, 0, 0);  // E48: timer restarted at E36
        // E: MUERTO with 5/1, presses discarded (rows 22-25)
        add(1,   0, 1, 1, 3'b000, 1, 5, 0, 0);
        add(48,  1, 1, 1, 3'b000, 5, 1, 0, 0);  // E48
        add(10,  1, 0, 0, 3'b101, 5, 1, 0, 0);
        add(200, 1, 1, 1, 3'b101, 5, 1, 0, 0);  // 50 ticks dead
        // F: timers hold while MUERTO and resume (rows 26-32)
        add(1,   0, 1, 1, 3'b000, 1, 5, 0, 0);
        add(28,  1, 1, 1, 3'b000, 3, 2, 0, 0);  // E28: hunger cnt 1, fun cnt 1
        add(40,  1, 1, 1, 3'b101, 3, 2, 0, 0);  // E68
        add(3,   1, 1, 1, 3'b000, 3, 2, 0, 0);  // E71
        add(1,   1, 1, 1, 3'b000, 3, 1, 0, 0);  // E72: fun resumes from 1
        add(3,   1, 1, 1, 3'b000, 3, 1, 0, 0);  // E75
        add(1,   1, 1, 1, 3'b000, 4, 1, 0, 0);  // E76: hunger resumes from 1
        // G: mid-debounce reset, then saturated presses on both buttons (rows 33-41)
        add(1,   0, 1, 1, 3'b000, 1, 5, 0, 0);
        add(24,  1, 1, 1, 3'b000, 3, 2, 0, 0);  // E24
        add(3,   1, 0, 0, 3'b000, 3, 2, 0, 0);  // E27: mid-debounce
        add(0,   0, 0, 0, 3'b000, 3, 2, 0, 0);  // reset low, no edge yet
        add(1,   0, 0, 0, 3'b000, 1, 5, 0, 0);  // reset edge R
        add(1,   1, 0, 0, 3'b000, 1, 5, 0, 0);  // R+1
        add(4,   1, 0, 0, 3'b000, 1, 5, 0, 0);  // R+5
        add(1,   1, 0, 0, 3'b000, 1, 5, 1, 1);  // R+6: pulses on saturated levels
        add(1,   1, 0, 0, 3'b000, 1, 5, 0, 0);

        reset_n = 1'b0; boton_comer_n = 1'b1; boton_jugar_n = 1'b1; estado = 3'b000;

        run_to(4);

        ec0 = n_ec; ej0 = n_ej;
        run_to(13);
        chk("held feed single pulse", 32'(n_ec - ec0), 32'd1);
        chk("held feed no play pulse", 32'(n_ej - ej0), 32'd0);

        run_to(15);
        ec0 = n_ec; ej0 = n_ej;
        for (int k = 0; k < 5; k++) begin
            boton_jugar_n = 1'b0;
            step(2);
            boton_jugar_n = 1'b1;
            step(2);
        end
        step(4);  // let any late debounce settle (E32)
        chk("bounce diversion", 32'(diversion), 32'd1);
        chk("bounce hambre", 32'(hambre), 32'd3);
        chk("bounce no play pulse", 32'(n_ej - ej0), 32'd0);
        chk("bounce no feed pulse", 32'(n_ec - ec0), 32'd0);

        ec0 = n_ec; ej0 = n_ej;
        run_to(21);
        chk("collision single pulse", 32'(n_ec - ec0), 32'd1);

        ec0 = n_ec; ej0 = n_ej;
        run_to(25);
        chk("dead no feed pulse", 32'(n_ec - ec0), 32'd0);
        chk("dead no play pulse", 32'(n_ej - ej0), 32'd0);

        run_to(32);

        ec0 = n_ec; ej0 = n_ej;
        run_to(41);
        chk("reset aborts debounce feed", 32'(n_ec - ec0), 32'd1);
        chk("reset aborts debounce play", 32'(n_ej - ej0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
